mgmt_uart_bridge: RTL and testbench

MGMT_UART_BRIDGE -- requirements
Module: mgmt_uart_bridge

---
 rtl/mgmt_uart_bridge.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mgmt_uart_bridge.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mgmt_uart_bridge.sv
// rtl/mgmt_uart_bridge.sv - host byte-stream to mgmt bus bridge (optional watchdog: MGMT_BRIDGE_TIMEOUT_EN)
module mgmt_uart_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_rx_vld,
    input  logic [7:0]  fifo_rx_dat,
    output logic        fifo_rx_rdy,
    input  logic        fifo_tx_rdy,
    output logic        fifo_tx_vld,
    output logic [7:0]  fifo_tx_dat,
    output logic        mgmt_req,
    output logic [31:0] mgmt_adr,
    output logic        mgmt_rwn,
    output logic [1:0]  mgmt_wen,
    output logic [31:0] mgmt_txd,
    input  logic        mgmt_ack,
    input  logic        mgmt_rxe,
    input  logic [31:0] mgmt_rxd,
    output logic        busy
);

    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADR,
        S_WEN,
        S_DAT,
        S_REQ,
        S_RXD,
        S_RSP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_idx;
    logic        r_req;
    logic [31:0] r_adr;
    logic        r_rwn;
    logic [1:0]  r_wen;
    logic [31:0] r_txd;
    logic [31:0] r_rxd;
    logic [7:0]  r_rsp_code;
    logic [2:0]  r_tx_last;
    logic [2:0]  r_tx_idx;
    logic        r_tx_vld;
    logic [7:0]  r_tx_dat;

    logic        w_rx_rdy;
    logic        w_rx_fire;
    logic        w_tx_fire;
    logic        w_ok;
    logic        w_tmo;
    logic        w_waiting;

    function automatic logic [7:0] rsp_byte(input logic [2:0] idx,
                                            input logic [7:0] code,
                                            input logic [31:0] d);
        case (idx)
            3'd0:    rsp_byte = code;
            3'd1:    rsp_byte = d[31:24];
            3'd2:    rsp_byte = d[23:16];
            3'd3:    rsp_byte = d[15:8];
            default: rsp_byte = d[7:0];
        endcase
    endfunction

    // rx_rdy is gated by rst so it reads 0 during reset and 1 on the first released cycle
    assign w_rx_rdy  = !rst && (r_state == S_IDLE || r_state == S_ADR ||
                                r_state == S_WEN  || r_state == S_DAT);
    assign w_rx_fire = fifo_rx_vld && w_rx_rdy;
    assign w_tx_fire = r_tx_vld && fifo_tx_rdy;
    assign w_waiting = (r_state == S_REQ) || (r_state == S_RXD);
    assign w_ok      = ((r_state == S_REQ) && mgmt_ack && (!r_rwn || mgmt_rxe)) ||
                       ((r_state == S_RXD) && mgmt_rxe);

`ifdef MGMT_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_waiting) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    assign w_tmo = w_waiting && (r_tmo_cnt >= TMO_LAST);
`else
    assign w_tmo = 1'b0;
    generate
        if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_out_of_range
        end
    endgenerate
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rx_fire) begin
                    if (fifo_rx_dat == OP_READ || fifo_rx_dat == OP_WRITE) begin
                        w_next = S_ADR;
                    end else begin
                        w_next = S_RSP;
                    end
                end
            end
            S_ADR: begin
                if (w_rx_fire && r_idx == 2'd3) begin
                    w_next = r_rwn ? S_REQ : S_WEN;
                end
            end
            S_WEN: begin
                if (w_rx_fire) begin
                    w_next = S_DAT;
                end
            end
            S_DAT: begin
                if (w_rx_fire && r_idx == 2'd3) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (w_ok || w_tmo) begin
                    w_next = S_RSP;
                end else if (mgmt_ack) begin
                    w_next = S_RXD;
                end
            end
            S_RXD: begin
                if (w_ok || w_tmo) begin
                    w_next = S_RSP;
                end
            end
            S_RSP: begin
                if (w_tx_fire && r_tx_idx == r_tx_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_req      <= 1'b0;
            r_adr      <= '0;
            r_rwn      <= 1'b0;
            r_wen      <= '0;
            r_txd      <= '0;
            r_rxd      <= '0;
            r_rsp_code <= '0;
            r_tx_last  <= '0;
            r_tx_idx   <= '0;
            r_tx_vld   <= 1'b0;
            r_tx_dat   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idx    <= '0;
                    r_tx_idx <= '0;
                    if (w_rx_fire) begin
                        if (fifo_rx_dat == OP_READ) begin
                            r_rwn <= 1'b1;
                            r_wen <= '0;
                            r_txd <= '0;
                        end else if (fifo_rx_dat == OP_WRITE) begin
                            r_rwn <= 1'b0;
                        end else begin
                            r_rsp_code <= RSP_NAK;
                            r_tx_last  <= 3'd0;
                        end
                    end
                end
                S_ADR: begin
                    if (w_rx_fire) begin
                        r_adr <= {r_adr[23:0], fifo_rx_dat};
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3 && r_rwn) begin
                            r_req <= 1'b1;
                        end
                    end
                end
                S_WEN: begin
                    if (w_rx_fire) begin
                        r_wen <= fifo_rx_dat[1:0];
                    end
                end
                S_DAT: begin
                    if (w_rx_fire) begin
                        r_txd <= {r_txd[23:0], fifo_rx_dat};
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_req <= 1'b1;
                        end
                    end
                end
                S_REQ, S_RXD: begin
                    if (mgmt_ack || w_tmo) begin
                        r_req <= 1'b0;
                    end
                    if (w_ok) begin
                        r_rsp_code <= RSP_ACK;
                        r_tx_last  <= r_rwn ? 3'd4 : 3'd0;
                        if (r_rwn) begin
                            r_rxd <= mgmt_rxd;
                        end
                    end else if (w_tmo) begin
                        r_req      <= 1'b0;
                        r_rsp_code <= RSP_NAK;
                        r_tx_last  <= 3'd0;
                    end
                end
                S_RSP: begin
                    // first RSP cycle only preloads the output byte register
                    if (!r_tx_vld) begin
                        r_tx_vld <= 1'b1;
                        r_tx_dat <= rsp_byte(r_tx_idx, r_rsp_code, r_rxd);
                    end else if (fifo_tx_rdy) begin
                        if (r_tx_idx == r_tx_last) begin
                            r_tx_vld <= 1'b0;
                            r_tx_dat <= '0;
                            r_tx_idx <= '0;
                        end else begin
                            r_tx_idx <= r_tx_idx + 3'd1;
                            r_tx_dat <= rsp_byte(r_tx_idx + 3'd1, r_rsp_code, r_rxd);
                        end
                    end
                end
                default: begin
                    r_req <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rx_rdy = w_rx_rdy;
    assign fifo_tx_vld = r_tx_vld;
    assign fifo_tx_dat = r_tx_dat;
    assign mgmt_req    = r_req;
    assign mgmt_adr    = r_adr;
    assign mgmt_rwn    = r_rwn;
    assign mgmt_wen    = r_wen;
    assign mgmt_txd    = r_txd;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mgmt_uart_bridge.sv
// tb/tb_mgmt_uart_bridge.sv - table-driven bench for mgmt_uart_bridge
module tb_mgmt_uart_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_rx_vld;
    logic [7:0]  fifo_rx_dat;
    logic        fifo_rx_rdy;
    logic        fifo_tx_rdy;
    logic        fifo_tx_vld;
    logic [7:0]  fifo_tx_dat;
    logic        mgmt_req;
    logic [31:0] mgmt_adr;
    logic        mgmt_rwn;
    logic [1:0]  mgmt_wen;
    logic [31:0] mgmt_txd;
    logic        mgmt_ack;
    logic        mgmt_rxe;
    logic [31:0] mgmt_rxd;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    mgmt_uart_bridge #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .fifo_rx_vld(fifo_rx_vld), .fifo_rx_dat(fifo_rx_dat), .fifo_rx_rdy(fifo_rx_rdy),
        .fifo_tx_rdy(fifo_tx_rdy), .fifo_tx_vld(fifo_tx_vld), .fifo_tx_dat(fifo_tx_dat),
        .mgmt_req(mgmt_req), .mgmt_adr(mgmt_adr), .mgmt_rwn(mgmt_rwn),
        .mgmt_wen(mgmt_wen), .mgmt_txd(mgmt_txd),
        .mgmt_ack(mgmt_ack), .mgmt_rxe(mgmt_rxe), .mgmt_rxd(mgmt_rxd),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [79:0] rx;
        int          rx_n;
        int          ack_d;
        int          rxe_d;
        logic [31:0] rxd;
        logic        exp_req;
        logic [31:0] exp_adr;
        logic        exp_rwn;
        logic [1:0]  exp_wen;
        logic [31:0] exp_txd;
        logic [39:0] tx;
        int          tx_n;
        int          rdy_mode;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        fifo_rx_vld = 1'b1;
        fifo_rx_dat = b;
        while (!fifo_rx_rdy && k < 20) begin
            tick();
            k++;
        end
        if (!fifo_rx_rdy) check("rx_accept_bound", 32'(fifo_rx_rdy), 32'd1);
        tick();
        fifo_rx_vld = 1'b0;
        fifo_rx_dat = 8'h00;
    endtask

    task automatic collect(input string tag, input logic [39:0] tx, input int tx_n,
                           input int mode, input logic no_req);
        int          cnt;
        logic [39:0] got;
        logic        req_seen;
        logic        rdy;
        cnt = 0;
        got = '0;
        req_seen = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            fifo_tx_rdy = rdy;
            if (fifo_tx_vld && rdy) begin
                if (cnt < 5) got[39 - 8*cnt -: 8] = fifo_tx_dat;
                cnt++;
            end
            if (mgmt_req) req_seen = 1'b1;
            tick();
        end
        fifo_tx_rdy = 1'b0;
        check({tag, " tx_count"}, 32'(cnt), 32'(tx_n));
        for (int i = 0; i < tx_n; i++)
            check($sformatf("%s tx_byte%0d", tag, i), 32'(got[39 - 8*i -: 8]), 32'(tx[39 - 8*i -: 8]));
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        if (no_req) check({tag, " no_req"}, 32'(req_seen), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic held;
        for (int i = 0; i < v.rx_n; i++) send_byte(v.rx[79 - 8*i -: 8]);
        if (v.exp_req) begin
            check({tag, " req_rise"}, 32'(mgmt_req), 32'd1);
            check({tag, " adr"}, mgmt_adr, v.exp_adr);
            check({tag, " rwn"}, 32'(mgmt_rwn), 32'(v.exp_rwn));
            check({tag, " wen"}, 32'(mgmt_wen), 32'(v.exp_wen));
            check({tag, " txd"}, mgmt_txd, v.exp_txd);
            held = 1'b1;
            for (int k = 0; k < v.ack_d; k++) begin
                tick();
                if (!mgmt_req) held = 1'b0;
            end
            mgmt_ack = 1'b1;
            if (v.rxe_d == 0) begin
                mgmt_rxe = 1'b1;
                mgmt_rxd = v.rxd;
            end
            tick();
            mgmt_ack = 1'b0;
            mgmt_rxe = 1'b0;
            mgmt_rxd = '0;
            check({tag, " req_held"}, 32'(held), 32'd1);
            check({tag, " req_drop"}, 32'(mgmt_req), 32'd0);
            if (v.exp_rwn && v.rxe_d > 0) begin
                for (int k = 0; k < v.rxe_d - 1; k++) tick();
                mgmt_rxe = 1'b1;
                mgmt_rxd = v.rxd;
                tick();
                mgmt_rxe = 1'b0;
                mgmt_rxd = '0;
            end
        end
        collect(tag, v.tx, v.tx_n, v.rdy_mode, !v.exp_req);
    endtask

    initial begin
        logic flag;
        int   cnt;

        vecs[0] = '{80'h52000010040000000000, 5, 2, 1, 32'hDEADBEEF, 1'b1, 32'h00001004, 1'b1, 2'd0, 32'h0,
                    40'h06DEADBEEF, 5, 0};
        vecs[1] = '{80'h57000020000312345678, 10, 0, 0, 32'h0, 1'b1, 32'h00002000, 1'b0, 2'd3, 32'h12345678,
                    40'h0600000000, 1, 0};
        vecs[2] = '{80'hAA000000000000000000, 1, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0, 2'd0, 32'h0,
                    40'h1500000000, 1, 0};
        vecs[3] = '{80'h52A55A00FF0000000000, 5, 0, 0, 32'h01020304, 1'b1, 32'hA55A00FF, 1'b1, 2'd0, 32'h0,
                    40'h0601020304, 5, 0};
        vecs[4] = '{80'h52123456780000000000, 5, 1, 2, 32'hCAFEF00D, 1'b1, 32'h12345678, 1'b1, 2'd0, 32'h0,
                    40'h06CAFEF00D, 5, 1};
        vecs[5] = '{80'h57FFFFFFFCFE80000001, 10, 3, 0, 32'h0, 1'b1, 32'hFFFFFFFC, 1'b0, 2'd2, 32'h80000001,
                    40'h0600000000, 1, 1};

        rst = 1'b1;
        fifo_rx_vld = 1'b0;
        fifo_rx_dat = '0;
        fifo_tx_rdy = 1'b0;
        mgmt_ack = 1'b0;
        mgmt_rxe = 1'b0;
        mgmt_rxd = '0;
        repeat (3) tick();
        check("reset rx_rdy", 32'(fifo_rx_rdy), 32'd0);
        check("reset tx_vld", 32'(fifo_tx_vld), 32'd0);
        check("reset req", 32'(mgmt_req), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset adr", mgmt_adr, 32'd0);
        rst = 1'b0;
        #1;
        check("release rx_rdy", 32'(fifo_rx_rdy), 32'd1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // ack/rxe while idle must not start anything
        flag = 1'b0;
        mgmt_ack = 1'b1;
        mgmt_rxe = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (busy || mgmt_req || fifo_tx_vld) flag = 1'b1;
        end
        mgmt_ack = 1'b0;
        mgmt_rxe = 1'b0;
        check("idle_ack_ignored", 32'(flag), 32'd0);

        // minimum latency: last rx byte -> tx valid on the third cycle, IDLE right after
        send_byte(8'h57);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
        send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        check("lat c1 req", 32'(mgmt_req), 32'd1);
        check("lat c1 tx_vld", 32'(fifo_tx_vld), 32'd0);
        mgmt_ack = 1'b1;
        tick();
        mgmt_ack = 1'b0;
        check("lat c2 tx_vld", 32'(fifo_tx_vld), 32'd0);
        tick();
        check("lat c3 tx_vld", 32'(fifo_tx_vld), 32'd1);
        check("lat c3 tx_dat", 32'(fifo_tx_dat), 32'h06);
        fifo_tx_rdy = 1'b1;
        tick();
        fifo_tx_rdy = 1'b0;
        check("lat idle tx_vld", 32'(fifo_tx_vld), 32'd0);
        check("lat idle busy", 32'(busy), 32'd0);

        // reset in the middle of the data phase
        send_byte(8'h57);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h12); send_byte(8'h34);
        rst = 1'b1;
        tick();
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst rx_rdy", 32'(fifo_rx_rdy), 32'd0);
        check("midrst req", 32'(mgmt_req), 32'd0);
        check("midrst adr", mgmt_adr, 32'd0);
        check("midrst wen", 32'(mgmt_wen), 32'd0);
        check("midrst txd", mgmt_txd, 32'd0);
        check("midrst tx_dat", 32'(fifo_tx_dat), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst release rx_rdy", 32'(fifo_rx_rdy), 32'd1);
        flag = 1'b0;
        fifo_tx_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (fifo_tx_vld) flag = 1'b1;
            tick();
        end
        fifo_tx_rdy = 1'b0;
        check("midrst no_tx", 32'(flag), 32'd0);
        run_vec(vecs[1], "post_rst_write");

`ifdef MGMT_BRIDGE_TIMEOUT_EN
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
        cnt = 0;
        while (mgmt_req && cnt < 30) begin
            cnt++;
            tick();
        end
        check("tmo req_cycles", 32'(cnt), 32'd8);
        mgmt_ack = 1'b1;
        mgmt_rxe = 1'b1;
        mgmt_rxd = 32'h55555555;
        tick();
        tick();
        mgmt_ack = 1'b0;
        mgmt_rxe = 1'b0;
        mgmt_rxd = '0;
        collect("tmo", 40'h1500000000, 1, 0, 1'b1);
`else
        cnt = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
